// File: rtl/perf_counter_monitor.sv
// Cycle / retired-instruction / event counter block with IDLE-RUN-HALTED control
// and a one-cycle registered read port. Counter index map: 0 cycles, 1 retired, 2+k events[k].
module perf_counter_monitor #(
   parameter int unsigned NUM_EVENTS      = 4,
   parameter int unsigned COMMIT_PORTS    = 2,
   parameter int unsigned CNT_WIDTH       = 32,
   parameter bit          SATURATE        = 1'b0,
   parameter bit          RESTART_ON_HOLD = 1'b1
) (
   input  logic                              sys_clk,
   input  logic                              ext_reset,
   input  logic                              fetch_hold,
   input  logic                              halt_req,
   input  logic                              clear,
   input  logic [COMMIT_PORTS-1:0]           retire_valid,
   input  logic [NUM_EVENTS-1:0]             events,
   input  logic                              rd_en,
   input  logic [$clog2(NUM_EVENTS+2)-1:0]   rd_addr,
   output logic [CNT_WIDTH-1:0]              rd_data,
   output logic                              rd_valid,
   output logic                              running,
   output logic                              halted,
   output logic [NUM_EVENTS+1:0]             overflow
);

   localparam int unsigned NCNT = NUM_EVENTS + 2;
   localparam int unsigned AW   = $clog2(NCNT);

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

   state_e               state_q, state_d;
   logic                 running_q, halted_q;
   logic [CNT_WIDTH-1:0] cnt_q [NCNT];
   logic [CNT_WIDTH-1:0] cnt_d [NCNT];
   logic [CNT_WIDTH:0]   inc   [NCNT];
   logic [CNT_WIDTH:0]   sum   [NCNT];
   logic [NCNT-1:0]      ovf_q, ovf_d;
   logic                 count_en, wipe;
   logic [CNT_WIDTH-1:0] rd_sel, rd_data_q;
   logic                 rd_valid_q;

   // wipe covers both clear and a restart-on-hold; clear outranks everything else
   always_comb begin
      count_en = (state_q != HALTED) && !fetch_hold && !clear;
      wipe     = clear || (RESTART_ON_HOLD && (state_q == RUN) && fetch_hold);
      state_d  = state_q;
      if (wipe)
         state_d = IDLE;
      else if (count_en)
         state_d = ((state_q == RUN) && halt_req) ? HALTED : RUN;
   end

   always_ff @(posedge sys_clk or posedge ext_reset) begin
      if (ext_reset) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == RUN);
         halted_q  <= (state_d == HALTED);
      end
   end

   // Sums carry one extra bit so the true overflow is visible before saturate/wrap
   always_comb begin
      for (int unsigned i = 0; i < NCNT; i++) inc[i] = '0;
      inc[0] = (CNT_WIDTH+1)'(1);
      for (int unsigned i = 0; i < COMMIT_PORTS; i++)
         inc[1] = inc[1] + (CNT_WIDTH+1)'(retire_valid[i]);
      for (int unsigned k = 0; k < NUM_EVENTS; k++)
         inc[2+k] = (CNT_WIDTH+1)'(events[k]);

      for (int unsigned i = 0; i < NCNT; i++) begin
         sum[i]   = {1'b0, cnt_q[i]} + inc[i];
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (wipe) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (count_en) begin
            if (sum[i][CNT_WIDTH]) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = SATURATE ? '1 : sum[i][CNT_WIDTH-1:0];
            end else begin
               cnt_d[i] = sum[i][CNT_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge sys_clk or posedge ext_reset) begin
      if (ext_reset) begin
         for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= '0;
         ovf_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
         ovf_q <= ovf_d;
      end
   end

   // Out-of-range addresses match no counter and read back as zero
   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i < NCNT; i++)
         if (rd_addr == AW'(i)) rd_sel = cnt_q[i];
   end

   always_ff @(posedge sys_clk or posedge ext_reset) begin
      if (ext_reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= rd_sel;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign running  = running_q;
   assign halted   = halted_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_perf_counter_monitor.sv
// Bench for perf_counter_monitor: three configurations share one stimulus stream and
// are compared every cycle against a per-configuration arithmetic reference model.
module tb_perf_counter_monitor;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   logic       clk = 1'b0;
   logic       rst, fh, hreq, clr, rd_en;
   logic [1:0] rv_in;
   logic [3:0] ev;
   logic [2:0] addr;

   logic [31:0] d0;
   logic [7:0]  d1, d2;
   logic        v0, v1, v2, r0, r1, r2, h0, h1, h2;
   logic [5:0]  o0, o1, o2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perf_counter_monitor #(.NUM_EVENTS(4), .COMMIT_PORTS(2), .CNT_WIDTH(32),
                          .SATURATE(1'b0), .RESTART_ON_HOLD(1'b1)) u_dut0 (
      .sys_clk(clk), .ext_reset(rst), .fetch_hold(fh), .halt_req(hreq), .clear(clr),
      .retire_valid(rv_in), .events(ev), .rd_en(rd_en), .rd_addr(addr),
      .rd_data(d0), .rd_valid(v0), .running(r0), .halted(h0), .overflow(o0));

   perf_counter_monitor #(.NUM_EVENTS(4), .COMMIT_PORTS(2), .CNT_WIDTH(8),
                          .SATURATE(1'b0), .RESTART_ON_HOLD(1'b0)) u_dut1 (
      .sys_clk(clk), .ext_reset(rst), .fetch_hold(fh), .halt_req(hreq), .clear(clr),
      .retire_valid(rv_in), .events(ev), .rd_en(rd_en), .rd_addr(addr),
      .rd_data(d1), .rd_valid(v1), .running(r1), .halted(h1), .overflow(o1));

   perf_counter_monitor #(.NUM_EVENTS(4), .COMMIT_PORTS(2), .CNT_WIDTH(8),
                          .SATURATE(1'b1), .RESTART_ON_HOLD(1'b1)) u_dut2 (
      .sys_clk(clk), .ext_reset(rst), .fetch_hold(fh), .halt_req(hreq), .clear(clr),
      .retire_valid(rv_in), .events(ev), .rd_en(rd_en), .rd_addr(addr),
      .rd_data(d2), .rd_valid(v2), .running(r2), .halted(h2), .overflow(o2));

   // Reference model, one entry per configuration
   int               mw   [3] = '{32, 8, 8};
   bit               msat [3] = '{1'b0, 1'b0, 1'b1};
   bit               mrh  [3] = '{1'b1, 1'b0, 1'b1};
   longint unsigned  mcnt [3][6];
   bit               movf [3][6];
   int               mstate [3];
   longint unsigned  mrd  [3];
   bit               mrv  [3];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         for (int k = 0; k < 6; k++) begin
            mcnt[m][k] = 0;
            movf[m][k] = 1'b0;
         end
         mstate[m] = S_IDLE;
         mrd[m]    = 0;
         mrv[m]    = 1'b0;
      end
   endtask

   task automatic model_edge();
      longint unsigned pre [6];
      longint unsigned inc [6];
      longint unsigned s, mx;
      if (rst) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 3; m++) begin
         pre = mcnt[m];
         mrv[m] = rd_en;
         if (rd_en) begin
            if (addr < 6) mrd[m] = pre[addr];
            else          mrd[m] = 0;
         end
         mx = (64'd1 << mw[m]) - 1;
         if (clr || (mstate[m] == S_RUN && fh && mrh[m])) begin
            for (int k = 0; k < 6; k++) begin
               mcnt[m][k] = 0;
               movf[m][k] = 1'b0;
            end
            mstate[m] = S_IDLE;
         end else if (mstate[m] != S_HALT && !fh) begin
            inc[0] = 1;
            inc[1] = $countones(rv_in);
            for (int k = 0; k < 4; k++) inc[2+k] = ev[k];
            for (int k = 0; k < 6; k++) begin
               s = mcnt[m][k] + inc[k];
               if (s > mx) begin
                  movf[m][k] = 1'b1;
                  mcnt[m][k] = msat[m] ? mx : (s & mx);
               end else begin
                  mcnt[m][k] = s;
               end
            end
            if (mstate[m] == S_IDLE)  mstate[m] = S_RUN;
            else if (hreq)            mstate[m] = S_HALT;
         end
      end
   endtask

   task automatic compare_all();
      logic [63:0] gd;
      logic        gv, gr, gh;
      logic [5:0]  go, eo;
      for (int m = 0; m < 3; m++) begin
         case (m)
            0:       begin gd = 64'(d0); gv = v0; gr = r0; gh = h0; go = o0; end
            1:       begin gd = 64'(d1); gv = v1; gr = r1; gh = h1; go = o1; end
            default: begin gd = 64'(d2); gv = v2; gr = r2; gh = h2; go = o2; end
         endcase
         for (int k = 0; k < 6; k++) eo[k] = movf[m][k];
         check_eq($sformatf("rd_data%0d", m),  gd, mrd[m]);
         check_eq($sformatf("rd_valid%0d", m), 64'(gv), 64'(mrv[m]));
         check_eq($sformatf("running%0d", m),  64'(gr), 64'(mstate[m] == S_RUN));
         check_eq($sformatf("halted%0d", m),   64'(gh), 64'(mstate[m] == S_HALT));
         check_eq($sformatf("overflow%0d", m), 64'(go), 64'(eo));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b0; fh = 1'b1; hreq = 1'b0; clr = 1'b0; rd_en = 1'b0;
      rv_in = '0; ev = '0; addr = '0;
      model_reset();
      #1 rst = 1'b1;

      // Reset, hold, then 10 counted cycles
      repeat (5) step();
      check_eq("rst_rd_data", 64'(d0), 0);
      check_eq("rst_rd_valid", 64'(v0), 0);
      check_eq("rst_running", 64'(r0), 0);
      check_eq("rst_overflow", 64'(o0), 0);
      rst = 1'b0;
      repeat (3) step();
      check_eq("hold_idle_running", 64'(r0), 0);
      fh = 1'b0;
      repeat (10) step();
      rd_en = 1'b1; addr = 3'd0;
      step();
      check_eq("plan_cycles10", 64'(d0), 10);
      check_eq("plan_running", 64'(r0), 1);
      rd_en = 1'b0;
      step();
      check_eq("rd_valid_drop", 64'(v0), 0);

      // Retire popcount
      clr = 1'b1; step(); clr = 1'b0;
      rv_in = 2'b11; repeat (4) step();
      rv_in = 2'b01; repeat (3) step();
      rv_in = 2'b00; repeat (2) step();
      rd_en = 1'b1; addr = 3'd1; step(); rd_en = 1'b0;
      check_eq("plan_retired11", 64'(d0), 11);

      // Halt with toggling event
      clr = 1'b1; step(); clr = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         ev   = {3'b000, c[0]};
         hreq = (c == 20);
         step();
      end
      hreq = 1'b0;
      for (int c = 21; c <= 30; c++) begin
         ev = {3'b000, c[0]};
         step();
      end
      check_eq("plan_halted", 64'(h0), 1);
      check_eq("plan_halt_not_running", 64'(r0), 0);
      hreq = 1'b1; fh = 1'b1; repeat (3) step();
      hreq = 1'b0; fh = 1'b0; ev = '0;
      rd_en = 1'b1; addr = 3'd0; step();
      check_eq("plan_halt_cycles20", 64'(d0), 20);
      addr = 3'd2; step();
      check_eq("plan_halt_event10", 64'(d0), 10);
      check_eq("plan_still_halted", 64'(h0), 1);
      rd_en = 1'b0;

      // Overflow, 8-bit wrap and saturate
      clr = 1'b1; step(); clr = 1'b0;
      repeat (260) step();
      rd_en = 1'b1; addr = 3'd0; step(); rd_en = 1'b0;
      check_eq("plan_wrap4", 64'(d1), 4);
      check_eq("plan_sat255", 64'(d2), 255);
      check_eq("plan_wide260", 64'(d0), 260);
      check_eq("plan_wrap_ovf", 64'(o1[0]), 1);
      check_eq("plan_sat_ovf", 64'(o2[0]), 1);

      // Restart-on-hold vs pause-on-hold
      clr = 1'b1; step(); clr = 1'b0;
      repeat (7) step();
      fh = 1'b1; step();
      check_eq("restart_to_idle", 64'(r0), 0);
      check_eq("pause_stays_run", 64'(r1), 1);
      step();
      fh = 1'b0; repeat (3) step();
      rd_en = 1'b1; addr = 3'd0; step(); rd_en = 1'b0;
      check_eq("plan_restart3", 64'(d0), 3);
      check_eq("plan_pause10", 64'(d1), 10);

      // Read on a counted edge, clear during read, then read zero
      clr = 1'b1; step(); clr = 1'b0;
      repeat (5) step();
      rd_en = 1'b1; addr = 3'd0; step();
      check_eq("plan_preinc5", 64'(d0), 5);
      step();
      check_eq("plan_next6", 64'(d0), 6);
      clr = 1'b1; step(); clr = 1'b0;
      check_eq("clear_read_preclear", 64'(d0), 7);
      fh = 1'b1; step();
      check_eq("plan_clear_read0", 64'(d0), 0);
      check_eq("plan_clear_ovf", 64'(o0), 0);
      check_eq("plan_clear_running", 64'(r0), 0);
      addr = 3'd6; step();
      check_eq("oor_read_zero", 64'(d0), 0);
      check_eq("oor_read_valid", 64'(v0), 1);
      rd_en = 1'b0; fh = 1'b0;

      // Randomized traffic with one asynchronous reset in the middle
      for (int i = 0; i < 600; i++) begin
         clr   = ($urandom_range(0, 24) == 0);
         fh    = ($urandom_range(0, 5) == 0);
         hreq  = ($urandom_range(0, 59) == 0);
         rv_in = 2'($urandom);
         ev    = 4'($urandom);
         rd_en = 1'($urandom);
         addr  = 3'($urandom);
         step();
         if (i == 300) begin
            #2 rst = 1'b1;
            #1 model_reset();
            compare_all();
            check_eq("async_rst_rd_data", 64'(d0), 0);
            step();
            rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/perf_counter_monitor.md
# perf_counter_monitor

Parametrised, synthesizable cycle and event counter block for the Taiga core. It starts counting on the first cycle fetch is released by the GC unit, counts cycles, retired instructions across all commit ports, and a configurable number of event lines, and freezes everything on a halt request. Results are read through a registered read port. It replaces ad-hoc bench-side cycle counting and sits beside the core, fed from the GC unit and writeback/commit stage.

## Interface
- NUM_EVENTS, 4, number of generic event inputs (≥1)
- COMMIT_PORTS, 2, number of retire-valid lanes (≥1)
- CNT_WIDTH, 32, width of every counter (≥8)
- SATURATE, 0, 1 = saturate at all-ones on overflow, 0 = wrap modulo 2^CNT_WIDTH
- RESTART_ON_HOLD, 1, 1 = fetch_hold during RUN clears counters and returns to IDLE, 0 = fetch_hold pauses counting

- sys_clk  in  1  clock, rising edge
- ext_reset  in  1  asynchronous, active-high reset
- fetch_hold  in  1  GC unit fetch hold; counting is enabled only when low
- halt_req  in  1  stop request, RUN -> HALTED
- clear  in  1  synchronous clear of counters, flags and state
- retire_valid  in  COMMIT_PORTS  one bit per commit port retiring this cycle
- events  in  NUM_EVENTS  one bit per event occurring this cycle
- rd_en  in  1  read request
- rd_addr  in  $clog2(NUM_EVENTS+2)  0 = cycles, 1 = retired, 2+k = events[k]
- rd_data  out  CNT_WIDTH  read result
- rd_valid  out  1  rd_data valid
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- overflow  out  NUM_EVENTS+2  sticky per-counter overflow, same index map as rd_addr

## Operation
- States: IDLE, RUN, HALTED. Reset and clear force IDLE.
- IDLE -> RUN on an edge where fetch_hold = 0. IDLE stays while fetch_hold = 1; counters stay 0.
- Counted cycle: a cycle is counted iff, at its closing edge, state ∈ {IDLE, RUN}, fetch_hold = 0, clear = 0. This includes the IDLE->RUN transition cycle.
- On a counted cycle:
  - cycles += 1
  - retired += popcount(retire_valid), range 0..COMMIT_PORTS
  - events[k] counter += events[k]
- RUN with fetch_hold = 1:
  - RESTART_ON_HOLD = 1: all counters and overflow flags clear, state -> IDLE.
  - RESTART_ON_HOLD = 0: state stays RUN, counters freeze.
- RUN with halt_req = 1 and fetch_hold = 0: that cycle is counted, then state -> HALTED.
- HALTED: counters frozen. Exit only via clear or ext_reset. halt_req and fetch_hold are ignored.
- halt_req in IDLE is ignored.
- Priority: ext_reset > clear > fetch_hold > halt_req.
- Overflow is detected when the true sum exceeds 2^CNT_WIDTH−1.
  - SATURATE = 1: the counter holds all-ones.
  - SATURATE = 0: the counter takes the sum modulo 2^CNT_WIDTH.
  - In both modes the sticky overflow bit sets.
- Reads are allowed in any state. An rd_addr ≥ NUM_EVENTS+2 returns 0 with rd_valid = 1.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, running = 0, halted = 0, overflow = 0, all counters 0, state IDLE.
- Read latency is 1 cycle. rd_en sampled at edge t gives rd_valid = 1 and rd_data after edge t; rd_valid drops after the next edge without rd_en.
- rd_data returns the counter value held before edge t, i.e. the pre-increment value if the same cycle is counted. Back-to-back reads are supported every cycle.
- clear during a read: rd_data still shows the pre-clear value. The next read returns 0.
- running and halted are registered and reflect state after the edge; they are never both 1.
- ext_reset mid-operation asynchronously zeroes all state and outputs. Counting resumes only via IDLE -> RUN after reset is released.

## Test plan
- Hold ext_reset for 5 edges and fetch_hold for 3 more, then release fetch_hold for 10 edges and read addr 0 -> rd_data = 10, running = 1.
- COMMIT_PORTS = 2: in RUN apply retire_valid = 2'b11 for 4 cycles, 2'b01 for 3, 2'b00 for 2, then read addr 1 -> 11.
- Assert halt_req at cycle 20 with events[0] toggling every cycle from cycle 1, then wait 10 cycles -> halted = 1; cycles = 20 and events[0] = 10, both frozen; a later halt_req or fetch_hold changes nothing.
- CNT_WIDTH = 8, run 260 cycles:
  - SATURATE = 0: cycles reads 4, overflow[0] = 1.
  - SATURATE = 1: cycles reads 255, overflow[0] = 1.
- RESTART_ON_HOLD = 1: count 7 cycles, pulse fetch_hold for 2, release for 3 -> cycles = 3, state passed through IDLE. With RESTART_ON_HOLD = 0 the same stimulus gives cycles = 10.
- Read addr 0 on the same edge a counted cycle occurs with a value of 5 -> rd_data = 5; the next read returns 6. Clear then read -> 0, overflow = 0, running = 0.
